// File: rtl/pll_reconfig_seq_pkg.sv
// Shared types and control-word layout for the PLL retune sequencer.
// The field offsets mirror map_top's decode of the PLL control word.
package pllSeq_pkg;
    typedef enum logic [3:0] {
        S_IDLE,
        S_DIS,
        S_SETTLE,
        S_EN,
        S_WAIT_LOCK,
        S_STABLE,
        S_LOCKED,
        S_RELOCK_WAIT,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic [1:0] zsel;
        logic [9:0] ratio;
        logic [1:0] mdiv;
    } cfg_t;

    localparam logic [1:0] CTRL_ADDR_DEF = 2'd1;
    localparam int PLLEN_BIT = 0;
    localparam int MDIV_LSB  = 1;
    localparam int RATIO_LSB = 3;
    localparam int ZSEL_LSB  = 13;

    function automatic logic [15:0] pack_ctrl(input cfg_t c, input logic pllen);
        logic [15:0] w;
        w = '0;
        w[PLLEN_BIT]        = pllen;
        w[MDIV_LSB +: 2]    = c.mdiv;
        w[RATIO_LSB +: 10]  = c.ratio;
        w[ZSEL_LSB +: 2]    = c.zsel;
        return w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Retune request handshake plus the map_top write port.
interface pll_reconfig_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_ratio;
    logic [1:0]  req_mdiv;
    logic [1:0]  req_zsel;
    logic        map_valid;
    logic [1:0]  map_address;
    logic [15:0] map_data;

    modport master (
        output req_valid, req_ratio, req_mdiv, req_zsel,
        input  req_ready, map_valid, map_address, map_data
    );
    modport slave (
        input  req_valid, req_ratio, req_mdiv, req_zsel,
        output req_ready, map_valid, map_address, map_data
    );
endinterface

// File: rtl/pll_reconfig_seq_sync.sv
// Two-flop synchronizer for signals arriving from another clock domain.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_reconfig_seq.sv
// Turns one retune request into disable / program / enable writes to map_top,
// then qualifies ringpll lock with a stability window, timeout and retries.
module pll_reconfig_seq import pllSeq_pkg::*; #(
    parameter int         SETTLE_CYC   = 16,
    parameter int         LOCK_TIMEOUT = 4096,
    parameter int         STABLE_CYC   = 64,
    parameter int         MAX_RETRY    = 3,
    parameter logic [1:0] CTRL_ADDR    = CTRL_ADDR_DEF
) (
    input  logic                clk,
    input  logic                rst,
    pll_reconfig_seq_if.slave   bus,
    input  logic                pll_lock,
    output logic                busy,
    output logic                locked,
    output logic                err,
    output logic [1:0]          retry_cnt
);
    localparam int CW = $clog2(max3(SETTLE_CYC, LOCK_TIMEOUT, STABLE_CYC));
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYC - 1);
    localparam logic [1:0]    MAX_R     = 2'(MAX_RETRY);

    state_t        state, state_d;
    cfg_t          cfg;
    logic [CW-1:0] cnt, tmo_cnt;
    logic [1:0]    addr_q;
    logic [15:0]   data_q, word;
    logic          lock_s, accept, timeout;

    sync_2ff #(.W(1)) u_lock_sync (.clk(clk), .rst(rst), .d(pll_lock), .q(lock_s));

    assign accept  = bus.req_valid && bus.req_ready;
    assign timeout = !lock_s && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE, S_ERROR: if (accept) state_d = S_DIS;
            S_LOCKED: begin
                // A new request beats a simultaneous lock drop.
                if (accept)       state_d = S_DIS;
                else if (!lock_s) state_d = S_RELOCK_WAIT;
            end
            S_RELOCK_WAIT: begin
                if (accept)                       state_d = S_DIS;
                else if (lock_s && cnt == STB_LAST) state_d = S_LOCKED;
            end
            S_DIS:    state_d = S_SETTLE;
            S_SETTLE: if (cnt == '0) state_d = S_EN;
            S_EN:     state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (lock_s)       state_d = S_STABLE;
                else if (timeout) state_d = (retry_cnt < MAX_R) ? S_DIS : S_ERROR;
            end
            S_STABLE: begin
                if (!lock_s)             state_d = S_WAIT_LOCK;
                else if (cnt == STB_LAST) state_d = S_LOCKED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        word            = pack_ctrl(cfg, state == S_EN);
        bus.map_valid   = (state == S_DIS) || (state == S_EN);
        bus.map_address = bus.map_valid ? CTRL_ADDR : addr_q;
        bus.map_data    = bus.map_valid ? word : data_q;
        bus.req_ready   = state inside {S_IDLE, S_LOCKED, S_ERROR, S_RELOCK_WAIT};
        busy            = state inside {S_DIS, S_SETTLE, S_EN, S_WAIT_LOCK, S_STABLE};
        locked          = (state == S_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg       <= '0;
            cnt       <= '0;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            err       <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            if (accept) begin
                cfg.ratio <= bus.req_ratio;
                cfg.mdiv  <= bus.req_mdiv;
                cfg.zsel  <= bus.req_zsel;
                retry_cnt <= '0;
                err       <= 1'b0;
            end
            if (bus.map_valid) begin
                addr_q <= CTRL_ADDR;
                data_q <= word;
            end
            case (state)
                S_DIS:    cnt <= SETTLE_LD;
                S_SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
                S_EN:     tmo_cnt <= '0;
                S_WAIT_LOCK: begin
                    // tmo_cnt survives STABLE excursions so lock time stays bounded.
                    cnt <= '0;
                    if (timeout) begin
                        if (retry_cnt < MAX_R) retry_cnt <= retry_cnt + 2'd1;
                        else                   err <= 1'b1;
                    end else if (tmo_cnt != TMO_LAST) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_STABLE, S_RELOCK_WAIT: cnt <= lock_s ? cnt + 1'b1 : '0;
                S_LOCKED: cnt <= '0;
                default: ;
            endcase
        end
    end
endmodule
